// File: rtl/ring_counter_pkg.sv
// ring_counter_pkg
//   Shared definitions for the ring/Johnson counter block.
//   - MODE_RING / MODE_JOHNSON : encoding of the mode input.
//   - seed(mode)               : start pattern of a mode, MAX_W bits wide;
//                                callers cast it down to their own width.
//   - is_legal_ring(q)         : exactly one bit set.
//   - is_legal_johnson(q, w)   : at most one adjacent-bit transition in q[w-1:0].
//   Callers zero-extend narrower codes to MAX_W before calling the checks.
package ring_counter_pkg;

  localparam int MAX_W = 32;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;

  localparam logic [MAX_W-1:0] ONE = {{(MAX_W-1){1'b0}}, 1'b1};

  function automatic logic [MAX_W-1:0] seed(logic mode);
    return (mode == MODE_JOHNSON) ? '0 : ONE;
  endfunction

  // One-hot test: non-zero and clearing the lowest set bit leaves nothing.
  function automatic logic is_legal_ring(logic [MAX_W-1:0] q);
    return (q != '0) && ((q & (q - ONE)) == '0);
  endfunction

  // A Johnson code is a single run of ones against a run of zeros, so at
  // most one neighbouring pair may differ inside the active width.
  function automatic logic is_legal_johnson(logic [MAX_W-1:0] q, int w);
    logic [MAX_W-1:0] d;
    d = '0;
    for (int i = 0; i < MAX_W - 1; i++) begin
      if (i < w - 1) d[i] = q[i] ^ q[i+1];
    end
    return (d & (d - ONE)) == '0;
  endfunction

endpackage

// File: rtl/ring_counter_gen_ring_code_check.sv
// ring_code_check
//   Combinational legality check of a counter code for the active mode.
//   Ports:
//     mode  in  1      0 = ring, 1 = Johnson
//     q     in  WIDTH  code under test
//     legal out 1      1 when q is a valid code for mode
import ring_counter_pkg::*;

module ring_code_check #(
  parameter int WIDTH = 4
) (
  input  logic             mode,
  input  logic [WIDTH-1:0] q,
  output logic             legal
);

  logic [MAX_W-1:0] q_ext;
  logic             ring_ok;
  logic             john_ok;

  assign q_ext   = MAX_W'(q);
  assign ring_ok = is_legal_ring(q_ext);
  assign john_ok = is_legal_johnson(q_ext, WIDTH);
  assign legal   = (mode == MODE_JOHNSON) ? john_ok : ring_ok;

endmodule

// File: rtl/ring_counter_gen.sv
// ring_counter_gen
//   WIDTH-bit shift-register counter, ring (one-hot) or Johnson mode, either
//   direction, with enable, parallel load and a wrap pulse.
//   Optional self-correction (macro RING_SELF_CORRECT_EN) forces illegal codes
//   back to the seed of the registered mode and pulses err.
//   Ports:
//     clk        in  1      rising-edge clock
//     rst        in  1      synchronous active-high reset
//     en         in  1      advance one step
//     mode       in  1      0 = ring, 1 = Johnson
//     dir        in  1      0 = toward MSB, 1 = toward LSB
//     load       in  1      load load_data
//     load_data  in  WIDTH  parallel load value
//     count_out  out WIDTH  counter state
//     wrap       out 1      step landed on the seed
//     err        out 1      illegal code corrected (0 without the macro)
import ring_counter_pkg::*;

module ring_counter_gen #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] count_out,
  output logic             wrap,
  output logic             err
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] seed_in;   // seed of the incoming mode (reset / mode change)
  logic [WIDTH-1:0] seed_cur;  // seed of the registered mode (step / correction)
  logic [WIDTH-1:0] stepped;
  logic             fb;
  logic             corr;

  assign seed_in  = WIDTH'(seed(mode));
  assign seed_cur = WIDTH'(seed(mode_q));

`ifdef RING_SELF_CORRECT_EN
  logic legal;

  ring_code_check #(.WIDTH(WIDTH)) u_check (
    .mode  (mode_q),
    .q     (cnt_q),
    .legal (legal)
  );

  assign corr = ~legal;
`else
  assign corr = 1'b0;
`endif

  // Bit shifted into the vacated end: plain rotate for ring, inverted for Johnson.
  always_comb begin
    fb = dir ? cnt_q[0] : cnt_q[WIDTH-1];
    if (mode_q == MODE_JOHNSON) fb = ~fb;
    stepped = dir ? {fb, cnt_q[WIDTH-1:1]} : {cnt_q[WIDTH-2:0], fb};
  end

  always_comb begin
    cnt_d  = cnt_q;
    mode_d = mode_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (mode != mode_q) begin
      cnt_d  = seed_in;
      mode_d = mode;
    end else if (load) begin
      cnt_d = load_data;
    end else if (corr) begin
      cnt_d = seed_cur;
      err_d = 1'b1;
    end else if (en) begin
      cnt_d  = stepped;
      wrap_d = (stepped == seed_cur);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= seed_in;
      mode_q <= mode;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign count_out = cnt_q;
  assign wrap      = wrap_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ring_counter_gen.sv
module tb_ring_counter_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1, en = 1'b0, mode = 1'b0, dir = 1'b0, load = 1'b0;
  logic [3:0] ld4 = '0;
  logic [7:0] ld8 = '0;
  logic [3:0] cnt4;
  logic [7:0] cnt8;
  logic       wrap4, err4, wrap8, err8;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ring_counter_gen #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
    .load_data(ld4), .count_out(cnt4), .wrap(wrap4), .err(err4)
  );

  ring_counter_gen #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
    .load_data(ld8), .count_out(cnt8), .wrap(wrap8), .err(err8)
  );

`ifdef RING_SELF_CORRECT_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  // Reference model: one entry per instance (0 -> WIDTH 4, 1 -> WIDTH 8).
  int          mw [2] = '{4, 8};
  logic [63:0] m_cnt [2];
  logic        m_mode [2];
  logic        m_wrap [2];
  logic        m_err [2];

  function automatic logic [63:0] msk(int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] mseed(logic m);
    return m ? 64'd0 : 64'd1;
  endfunction

  // Legal Johnson codes are exactly the 2W states reached from zero:
  // k low ones (k = 0..W) or the mask with k low zeros.
  function automatic bit mlegal(logic [63:0] q, logic m, int w);
    if (!m) return $countones(q) == 1;
    for (int k = 0; k <= w; k++) begin
      if (q == ((64'd1 << k) - 64'd1)) return 1'b1;
      if (q == (msk(w) & ~((64'd1 << k) - 64'd1))) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [63:0] mstep(logic [63:0] q, logic m, logic d, int w);
    logic [63:0] top, low;
    top = (q >> (w - 1)) & 64'd1;
    low = q & 64'd1;
    if (m) begin
      top = top ^ 64'd1;
      low = low ^ 64'd1;
    end
    if (!d) return ((q << 1) & msk(w)) | top;
    return (q >> 1) | (low << (w - 1));
  endfunction

  task automatic model_upd(int i, logic [63:0] ld);
    m_wrap[i] = 1'b0;
    m_err[i]  = 1'b0;
    if (rst) begin
      m_cnt[i]  = mseed(mode);
      m_mode[i] = mode;
    end else if (mode != m_mode[i]) begin
      m_cnt[i]  = mseed(mode);
      m_mode[i] = mode;
    end else if (load) begin
      m_cnt[i] = ld & msk(mw[i]);
    end else if (SC && !mlegal(m_cnt[i], m_mode[i], mw[i])) begin
      m_cnt[i] = mseed(m_mode[i]);
      m_err[i] = 1'b1;
    end else if (en) begin
      m_cnt[i]  = mstep(m_cnt[i], m_mode[i], dir, mw[i]);
      m_wrap[i] = (m_cnt[i] == mseed(m_mode[i]));
    end
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge: advance the model from the driven inputs, then compare.
  task automatic tick();
    model_upd(0, 64'(ld4));
    model_upd(1, 64'(ld8));
    @(posedge clk);
    #1;
    chk("cnt4", 64'(cnt4), m_cnt[0]);
    chk("wrap4", 64'(wrap4), 64'(m_wrap[0]));
    chk("err4", 64'(err4), 64'(m_err[0]));
    chk("cnt8", 64'(cnt8), m_cnt[1]);
    chk("wrap8", 64'(wrap8), 64'(m_wrap[1]));
    chk("err8", 64'(err8), 64'(m_err[1]));
  endtask

  logic [3:0] ring_seq [8] = '{4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
  logic [3:0] john_seq [8] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
  logic [3:0] john_rt  [3] = '{4'h8, 4'hC, 4'hE};

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = '0; m_mode[i] = 1'b0; m_wrap[i] = 1'b0; m_err[i] = 1'b0;
    end

    // Reset in ring mode
    rst = 1'b1; mode = 1'b0; en = 1'b0; dir = 1'b0;
    @(negedge clk);
    tick();
    chk("rst_cnt4", 64'(cnt4), 64'h1);
    chk("rst_wrap4", 64'(wrap4), 64'h0);
    chk("rst_err4", 64'(err4), 64'h0);

    // Ring left, wrap on each return to 0001
    rst = 1'b0; en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("ring_seq", 64'(cnt4), 64'(ring_seq[k]));
      chk("ring_wrap", 64'(wrap4), 64'(ring_seq[k] == 4'h1));
    end

    // Johnson from reset, then reverse direction
    rst = 1'b1; mode = 1'b1; tick();
    chk("john_rst", 64'(cnt4), 64'h0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("john_seq", 64'(cnt4), 64'(john_seq[k]));
      chk("john_wrap", 64'(wrap4), 64'(k == 7));
    end
    dir = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("john_rt", 64'(cnt4), 64'(john_rt[k]));
    end

    // Mode toggles reseed and suppress the step
    dir = 1'b0; mode = 1'b0; rst = 1'b1; tick();
    rst = 1'b0; tick(); tick();
    chk("ring_0100", 64'(cnt4), 64'h4);
    mode = 1'b1; tick();
    chk("mchg_cnt", 64'(cnt4), 64'h0);
    chk("mchg_wrap", 64'(wrap4), 64'h0);
    mode = 1'b0; tick();
    chk("mchg_back", 64'(cnt4), 64'h1);

    // Load of an illegal ring code with en high
    load = 1'b1; ld4 = 4'hA; ld8 = 8'h0A; tick();
    chk("load_cnt", 64'(cnt4), 64'hA);
    load = 1'b0; tick();
    chk("ld_next", 64'(cnt4), SC ? 64'h1 : 64'h5);
    chk("ld_err", 64'(err4), 64'(SC));
    tick();
    chk("ld_next2", 64'(cnt4), SC ? 64'h2 : 64'hA);
    chk("ld_err2", 64'(err4), 64'h0);

    // Reset mid-count in Johnson mode
    mode = 1'b1; rst = 1'b1; tick();
    rst = 1'b0; tick(); tick(); tick();
    chk("john_0111", 64'(cnt4), 64'h7);
    rst = 1'b1; tick();
    chk("mid_rst", 64'(cnt4), 64'h0);
    chk("mid_rst_wrap", 64'(wrap4), 64'h0);
    rst = 1'b0; tick();
    chk("resume", 64'(cnt4), 64'h1);

    // WIDTH 8 Johnson: wrap at steps 16 and 32 only
    rst = 1'b1; tick();
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk("w8_wrap", 64'(wrap8), 64'(k == 16 || k == 32));
    end

    // Hold with en low
    en = 1'b0; tick(); tick();
    chk("hold_cnt8", 64'(cnt8), 64'h0);
    chk("hold_wrap8", 64'(wrap8), 64'h0);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      rst  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      load = ($urandom_range(0, 9) == 0);
      en   = ($urandom_range(0, 3) != 0);
      dir  = 1'($urandom);
      ld4  = 4'($urandom);
      ld8  = 8'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
